// File: rtl/norm_sqrt_pkg.sv
// Shared types and width helpers for the Euclidean-norm square-root stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package norm_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radicand width; must match the upstream adder-tree output width.
  function automatic int in_w(input int dw);
    return 2 * dw + 2;
  endfunction

  // Root width: half the radicand width.
  function automatic int rt_w(input int dw);
    return dw + 1;
  endfunction

  // Remainder width: rem <= 2*root, so one bit wider than the root.
  function automatic int rem_w(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/norm_sqrt_step.sv
// One restoring square-root iteration: resolves a single root bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_in   partial remainder so far
//   root_in  partial root so far
//   two_bits next two radicand bits, MSB first
//   rem_out  updated partial remainder
//   root_out partial root with the new bit appended
module norm_sqrt_step
  import norm_sqrt_pkg::*;
#(
  parameter int RT_W  = 5,
  parameter int REM_W = 6
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic [RT_W-1:0]  root_in,
  input  logic [1:0]       two_bits,
  output logic [REM_W-1:0] rem_out,
  output logic [RT_W-1:0]  root_out
);

  // One spare bit beyond the magnitude range so the MSB is a clean sign.
  localparam int TW = REM_W + 2;

  logic [TW-1:0] cat;
  logic [TW-1:0] trial;
  logic [TW-1:0] diff;
  logic          fits;

  assign cat   = {rem_in, two_bits};
  assign trial = TW'({root_in, 2'b01});
  assign diff  = cat - trial;
  assign fits  = ~diff[TW-1];

  // Restoring step: keep the subtraction only if it did not go negative.
  // The upper bits dropped by the casts are always zero for in-range
  // partial values (rem <= 2*root, root fills at most RT_W-1 bits here).
  assign rem_out  = fits ? REM_W'(diff) : REM_W'(cat);
  assign root_out = RT_W'({root_in, fits});

endmodule

// File: rtl/norm_sqrt_unit.sv
// Iterative integer square root: root = floor(sqrt(radicand)), remainder = radicand - root^2.
// Latency: o_valid rises RT_W cycles after the accept edge; one result per RT_W+2 cycles max.
// Backpressure: result held bit-stable while o_valid && !o_ready; i_ready low until delivered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   i_valid    radicand valid
//   i_ready    unit idle and able to accept a radicand
//   radicand   unsigned sum-of-squares input (IN_W bits)
//   o_valid    root/remainder valid
//   o_ready    downstream accepts the result
//   root       floor(sqrt(radicand)) (RT_W bits)
//   remainder  radicand - root*root (REM_W bits)
module norm_sqrt_unit
  import norm_sqrt_pkg::*;
#(
  parameter int DATAWIDTH   = 4,
  parameter int INSTANCE_ID = 0,
  localparam int IN_W  = in_w(DATAWIDTH),
  localparam int RT_W  = rt_w(DATAWIDTH),
  localparam int REM_W = rem_w(DATAWIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [IN_W-1:0]  radicand,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [RT_W-1:0]  root,
  output logic [REM_W-1:0] remainder
);

  localparam int CNT_W = (RT_W > 1) ? $clog2(RT_W) : 1;

  state_e           state;
  logic [IN_W-1:0]  shreg;
  logic [RT_W-1:0]  root_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt;

  logic [RT_W-1:0]  root_nx;
  logic [REM_W-1:0] rem_nx;

  norm_sqrt_step #(
    .RT_W  (RT_W),
    .REM_W (REM_W)
  ) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .two_bits (shreg[IN_W-1 -: 2]),
    .rem_out  (rem_nx),
    .root_out (root_nx)
  );

  // Handshake flags are pure decodes of the state register.
  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  // The partial root/remainder registers double as the output registers;
  // they only change in CALC, so they are frozen for the whole DONE stay.
  assign root      = root_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            shreg  <= radicand;
            root_q <= '0;
            rem_q  <= '0;
            cnt    <= CNT_W'(RT_W - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          shreg  <= {shreg[IN_W-3:0], 2'b00};
          root_q <= root_nx;
          rem_q  <= rem_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (o_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sqrt_unit.sv
// Self-checking bench for norm_sqrt_unit at DATAWIDTH=4 (IN_W=10, RT_W=5, REM_W=6).
// Latency: checks o_valid arrives exactly 5 cycles after the accept edge.
// Backpressure: exercises held results under o_ready=0 and reset during a calculation.
module tb_norm_sqrt_unit;

  localparam int IN_W  = 10;
  localparam int RT_W  = 5;
  localparam int REM_W = 6;
  localparam int LAT   = 5;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             i_ready;
  logic [IN_W-1:0]  radicand;
  logic             o_valid;
  logic             o_ready;
  logic [RT_W-1:0]  root;
  logic [REM_W-1:0] remainder;

  int n_vec;
  int n_bad;

  norm_sqrt_unit #(
    .DATAWIDTH   (4),
    .INSTANCE_ID (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .radicand  (radicand),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .root      (root),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int exp_root;
    int exp_rem;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, by plain search.
  function automatic int model_root(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Enters and leaves on a falling edge. Pushes one radicand through,
  // optionally toggling i_valid/radicand with noise while the unit is busy.
  task automatic apply(input int x, input int exp_r, input int exp_m,
                       input int hold, input bit noisy, input bit chk_lat);
    int wait_c;
    int lat;
    wait_c = 0;
    while (!i_ready && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    if (!i_ready) chk("i_ready_timeout", 0, 1);
    i_valid  = 1'b1;
    radicand = IN_W'(x);
    @(posedge clk);
    @(negedge clk);
    i_valid  = 1'b0;
    radicand = IN_W'($urandom);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (noisy) begin
        i_valid  = 1'($urandom_range(0, 1));
        radicand = IN_W'($urandom);
      end
    end
    i_valid = 1'b0;
    if (!o_valid) chk("o_valid_timeout", 0, 1);
    if (chk_lat) chk("latency", lat, LAT);
    chk("root", int'(root), exp_r);
    chk("remainder", int'(remainder), exp_m);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_o_valid", int'(o_valid), 1);
      chk("hold_i_ready", int'(i_ready), 0);
      chk("hold_root", int'(root), exp_r);
      chk("hold_remainder", int'(remainder), exp_m);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("release_o_valid", int'(o_valid), 0);
    chk("release_i_ready", int'(i_ready), 1);
  endtask

  vec_t vecs[8];
  int   order[1024];

  initial begin
    int tmp;
    int j;
    int r;
    bool_blk: begin end
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    i_valid  = 1'b0;
    o_ready  = 1'b0;
    radicand = '0;

    vecs[0] = '{0,    0,  0};
    vecs[1] = '{900,  30, 0};
    vecs[2] = '{899,  29, 58};
    vecs[3] = '{1023, 31, 62};
    vecs[4] = '{1,    1,  0};
    vecs[5] = '{2,    1,  1};
    vecs[6] = '{4,    2,  0};
    vecs[7] = '{500,  22, 16};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", int'(i_ready), 1);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_root", int'(root), 0);
    chk("rst_remainder", int'(remainder), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, latency checked on every entry
    foreach (vecs[k]) begin
      apply(vecs[k].x, vecs[k].exp_root, vecs[k].exp_rem, 0, 1'b0, 1'b1);
    end

    // Backpressure: result held for 10 cycles
    apply(899, 29, 58, 10, 1'b0, 1'b1);

    // Reset in the middle of a calculation
    i_valid  = 1'b1;
    radicand = IN_W'(500);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_i_ready", int'(i_ready), 1);
    chk("abort_o_valid", int'(o_valid), 0);
    chk("abort_root", int'(root), 0);
    chk("abort_remainder", int'(remainder), 0);
    tmp = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_valid) tmp = 1;
    end
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) tmp = 1;
    end
    chk("abort_no_o_valid", tmp, 0);
    apply(500, 22, 16, 0, 1'b0, 1'b1);

    // Shuffled sweep of every radicand with random noise and hold times
    for (int i = 0; i < 1024; i++) order[i] = i;
    for (int i = 1023; i > 0; i--) begin
      j        = $urandom_range(0, i);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 1024; i++) begin
      r = model_root(order[i]);
      apply(order[i], r, order[i] - r * r, $urandom_range(0, 2), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
